mpu_spi_slave_model: RTL and testbench
======================================

MPU_SPI_SLAVE_MODEL -- requirements
Module: mpu_spi_slave_model

Interface
REQ-001 SHALL have parameter WHO_AM_I_VAL, default 8'h71, value returned at register 0x75.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for spi_ss/spi_sck/spi_mosi.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports spi_ss in 1 (active-low select); spi_sck in 1; spi_mosi in 1; spi_miso out 1; spi_miso_oe out 1 (high while selected).
REQ-006 SHALL have ports accel_x_in, accel_y_in, accel_z_in  in  16 each  sensor sample, signed.
REQ-007 SHALL have port sample_valid  in  1  one-cycle strobe loading a new sample.
REQ-008 SHALL have ports pwr_mgmt_1 out 8 (reg 0x6B); int_pin_cfg out 8 (reg 0x37).
REQ-009 SHALL have ports wr_strobe out 1, wr_addr out 7, wr_data out 8: one-cycle pulse per completed write byte.
REQ-010 SHALL have port frame_error  out 1  one-cycle pulse on malformed frame.

Function
REQ-011 SHALL implement SPI mode 3, MSB first: sample MOSI on SCK rising edge, update MISO on SCK falling edge; SCK <= clk/8.
REQ-012 SHALL detect SCK edges and SS edges only from synchronized signals.
REQ-013 SHALL use FSM IDLE -> ADDR (8 bits) -> DATA (repeating 8-bit bytes) -> IDLE on SS rising; SS falling in IDLE enters ADDR with bit count 0.
REQ-014 SHALL decode address byte bit7 as R/W (1 = read), bits 6:0 as start address.
REQ-015 SHALL, on read, latch register byte at the 8th address-bit sample and present its bit7 on MISO at the following SCK falling edge.
REQ-016 SHALL auto-increment address after each data byte, wrapping 0x7F -> 0x00.
REQ-017 SHALL map reads: 0x3B/0x3C = x[15:8]/x[7:0], 0x3D/0x3E = y, 0x3F/0x40 = z, 0x6B, 0x37, 0x75 = WHO_AM_I_VAL, all others 8'h00.
REQ-018 SHALL write only 0x6B and 0x37; writes elsewhere ignored in storage but still reported on wr_strobe/wr_addr/wr_data.
REQ-019 SHALL assert wr_strobe one cycle after the 8th bit of each write data byte is sampled.
REQ-020 SHALL load shadow accel registers on sample_valid when SS is high; if SS low, hold the sample pending and apply it the cycle SS rises (coherent burst); newer strobe overwrites pending.
REQ-021 SHALL pulse frame_error when SS rises with bit count not a multiple of 8 or with zero data bytes after an address; partial write byte discarded.
REQ-022 SHALL drive spi_miso 0 when not selected or during address phase and write frames.
REQ-023 SHALL, on SS rising and SCK edge in the same cycle, honour SS rising only.

Reset
REQ-024 SHALL reset: FSM IDLE, pwr_mgmt_1 = 8'h01, int_pin_cfg = 8'h00, shadow accel = 0, pending cleared, spi_miso = 0, spi_miso_oe = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, frame_error = 0.
REQ-025 SHALL, after reset released with SS low, ignore the frame until SS is seen high.

Structure
REQ-026 SHALL place register addresses (0x3B-0x40, 0x6B, 0x37, 0x75) and reset values in shared package mpu9250_pkg, same values as the master's address defines.
REQ-027 SHALL use one sub-module spi_slave_sync (synchronizer plus SCK/SS edge detector); register file and FSM stay in top.

Verification
REQ-028 Read 0x75 (byte 8'hF5, one dummy byte) -> MISO returns 8'h71, no frame_error.
REQ-029 sample_valid with x=16'h1234, y=16'hABCD, z=16'h8001; burst read from 0x3B, 6 bytes -> 12 34 AB CD 80 01.
REQ-030 Write 0x6B<=8'h00 then 0x37<=8'h02 -> pwr_mgmt_1=00, int_pin_cfg=02, two wr_strobe pulses with addr 6B/37.
REQ-031 sample_valid x=16'h1111 mid-burst after first byte 8'h00 -> burst finishes with old data; next read gives 11 11.
REQ-032 SS raised after 5 data bits of write to 0x37 -> frame_error pulse, int_pin_cfg unchanged, no wr_strobe.
REQ-033 reset asserted mid-read with SS low -> outputs at reset values; rest of that frame ignored; next frame reads 0x75 correctly.

Source files
------------

// File: rtl/mpu9250_pkg.sv
// MPU-9250 register map shared by the SPI master and this slave model.
package mpu9250_pkg;

  localparam logic [6:0] ADDR_ACCEL_XOUT_H = 7'h3B;
  localparam logic [6:0] ADDR_ACCEL_XOUT_L = 7'h3C;
  localparam logic [6:0] ADDR_ACCEL_YOUT_H = 7'h3D;
  localparam logic [6:0] ADDR_ACCEL_YOUT_L = 7'h3E;
  localparam logic [6:0] ADDR_ACCEL_ZOUT_H = 7'h3F;
  localparam logic [6:0] ADDR_ACCEL_ZOUT_L = 7'h40;
  localparam logic [6:0] ADDR_PWR_MGMT_1   = 7'h6B;
  localparam logic [6:0] ADDR_INT_PIN_CFG  = 7'h37;
  localparam logic [6:0] ADDR_WHO_AM_I     = 7'h75;

  localparam logic [7:0] PWR_MGMT_1_RST  = 8'h01;
  localparam logic [7:0] INT_PIN_CFG_RST = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } spi_state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes the SPI pins into clk and derives SCK/SS edge strobes.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic i_ss,
  input  logic i_sck,
  input  logic i_mosi,
  output logic o_ss,
  output logic o_mosi,
  output logic o_ss_rise,
  output logic o_ss_fall,
  output logic o_sck_rise,
  output logic o_sck_fall
);

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_ss_d;
  logic                   r_sck_d;
  logic                   w_ss;
  logic                   w_sck;

  // SS resets low so a frame already in progress at reset release never
  // produces a falling edge; only a real high-then-low is seen as a select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_sync   <= '0;
      r_sck_sync  <= '1;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b0;
      r_sck_d     <= 1'b1;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_d      <= w_ss;
      r_sck_d     <= w_sck;
    end
  end

  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign o_ss       = w_ss;
  assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign o_ss_rise  = w_ss & ~r_ss_d;
  assign o_ss_fall  = ~w_ss & r_ss_d;
  assign o_sck_rise = w_sck & ~r_sck_d;
  assign o_sck_fall = ~w_sck & r_sck_d;

endmodule

// File: rtl/mpu_spi_slave_model.sv
// Behavioural MPU-9250 SPI slave (mode 3): accel shadow regs, PWR_MGMT_1,
// INT_PIN_CFG, WHO_AM_I, with write reporting and frame error detection.
module mpu_spi_slave_model
  import mpu9250_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h71,
  parameter int         SYNC_STAGES  = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               spi_ss,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  input  logic signed [15:0] accel_x_in,
  input  logic signed [15:0] accel_y_in,
  input  logic signed [15:0] accel_z_in,
  input  logic               sample_valid,
  output logic [7:0]         pwr_mgmt_1,
  output logic [7:0]         int_pin_cfg,
  output logic               wr_strobe,
  output logic [6:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               frame_error
);

  logic       w_ss_s, w_mosi_s, w_ss_rise, w_ss_fall, w_sck_rise, w_sck_fall;
  logic [7:0] w_rx_byte;

  spi_state_t r_state, w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_tx;
  logic        r_rw, r_got_byte, r_miso;
  logic [6:0]  r_addr;
  logic [7:0]  r_pwr, r_int;
  logic [15:0] r_ax, r_ay, r_az;
  logic [15:0] r_pend_x, r_pend_y, r_pend_z;
  logic        r_pend_valid;
  logic        r_wr_strobe, r_frame_error;
  logic [6:0]  r_wr_addr;
  logic [7:0]  r_wr_data;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_ss       (spi_ss),
    .i_sck      (spi_sck),
    .i_mosi     (spi_mosi),
    .o_ss       (w_ss_s),
    .o_mosi     (w_mosi_s),
    .o_ss_rise  (w_ss_rise),
    .o_ss_fall  (w_ss_fall),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall)
  );

  assign w_rx_byte = {r_shift[6:0], w_mosi_s};

  function automatic logic [7:0] reg_read(input logic [6:0] a);
    case (a)
      ADDR_ACCEL_XOUT_H: return r_ax[15:8];
      ADDR_ACCEL_XOUT_L: return r_ax[7:0];
      ADDR_ACCEL_YOUT_H: return r_ay[15:8];
      ADDR_ACCEL_YOUT_L: return r_ay[7:0];
      ADDR_ACCEL_ZOUT_H: return r_az[15:8];
      ADDR_ACCEL_ZOUT_L: return r_az[7:0];
      ADDR_PWR_MGMT_1:   return r_pwr;
      ADDR_INT_PIN_CFG:  return r_int;
      ADDR_WHO_AM_I:     return WHO_AM_I_VAL;
      default:           return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // SS rising takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_ss_fall) w_state_next = ST_ADDR;
      ST_ADDR: begin
        if (w_ss_rise)                             w_state_next = ST_IDLE;
        else if (w_sck_rise && r_bit_cnt == 3'd7)  w_state_next = ST_DATA;
      end
      ST_DATA: if (w_ss_rise) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_tx          <= '0;
      r_rw          <= 1'b0;
      r_got_byte    <= 1'b0;
      r_miso        <= 1'b0;
      r_addr        <= '0;
      r_pwr         <= PWR_MGMT_1_RST;
      r_int         <= INT_PIN_CFG_RST;
      r_ax          <= '0;
      r_ay          <= '0;
      r_az          <= '0;
      r_pend_x      <= '0;
      r_pend_y      <= '0;
      r_pend_z      <= '0;
      r_pend_valid  <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_wr_strobe   <= 1'b0;
      r_frame_error <= 1'b0;

      // Shadow regs only change while deselected so a burst stays coherent.
      if (sample_valid && w_ss_s) begin
        r_ax         <= accel_x_in;
        r_ay         <= accel_y_in;
        r_az         <= accel_z_in;
        r_pend_valid <= 1'b0;
      end else if (sample_valid) begin
        r_pend_x     <= accel_x_in;
        r_pend_y     <= accel_y_in;
        r_pend_z     <= accel_z_in;
        r_pend_valid <= 1'b1;
      end else if (w_ss_rise && r_pend_valid) begin
        r_ax         <= r_pend_x;
        r_ay         <= r_pend_y;
        r_az         <= r_pend_z;
        r_pend_valid <= 1'b0;
      end

      if (r_state != ST_IDLE && w_ss_rise) begin
        r_frame_error <= (r_bit_cnt != 3'd0) || !r_got_byte;
        r_miso        <= 1'b0;
      end else if (r_state == ST_IDLE && w_ss_fall) begin
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_got_byte <= 1'b0;
        r_miso     <= 1'b0;
      end else if (r_state != ST_IDLE && w_sck_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_rx_byte;
        if (r_bit_cnt == 3'd7) begin
          if (r_state == ST_ADDR) begin
            r_rw   <= w_rx_byte[7];
            r_addr <= w_rx_byte[6:0];
            r_tx   <= w_rx_byte[7] ? reg_read(w_rx_byte[6:0]) : 8'h00;
          end else begin
            r_got_byte <= 1'b1;
            r_addr     <= r_addr + 7'd1;
            if (r_rw) begin
              r_tx <= reg_read(r_addr + 7'd1);
            end else begin
              r_wr_strobe <= 1'b1;
              r_wr_addr   <= r_addr;
              r_wr_data   <= w_rx_byte;
              if (r_addr == ADDR_PWR_MGMT_1)  r_pwr <= w_rx_byte;
              if (r_addr == ADDR_INT_PIN_CFG) r_int <= w_rx_byte;
            end
          end
        end
      end else if (r_state == ST_DATA && w_sck_fall && r_rw) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = (r_state != ST_IDLE);
  assign pwr_mgmt_1  = r_pwr;
  assign int_pin_cfg = r_int;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_mpu_spi_slave_model.sv
// Directed bench for mpu_spi_slave_model: acts as a mode-3 SPI master.
module tb_mpu_spi_slave_model;

  localparam int HALF = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               spi_ss, spi_sck, spi_mosi;
  logic               spi_miso, spi_miso_oe;
  logic signed [15:0] accel_x_in, accel_y_in, accel_z_in;
  logic               sample_valid;
  logic [7:0]         pwr_mgmt_1, int_pin_cfg;
  logic               wr_strobe;
  logic [6:0]         wr_addr;
  logic [7:0]         wr_data;
  logic               frame_error;

  int total = 0;
  int bad   = 0;

  int         n_wr   = 0;
  int         n_ferr = 0;
  logic [6:0] wr_log_addr [16];
  logic [7:0] wr_log_data [16];
  logic [7:0] rx_buf [8];

  mpu_spi_slave_model dut (
    .clk          (clk),
    .reset        (reset),
    .spi_ss       (spi_ss),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .accel_x_in   (accel_x_in),
    .accel_y_in   (accel_y_in),
    .accel_z_in   (accel_z_in),
    .sample_valid (sample_valid),
    .pwr_mgmt_1   (pwr_mgmt_1),
    .int_pin_cfg  (int_pin_cfg),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) begin
      wr_log_addr[n_wr[3:0]] <= wr_addr;
      wr_log_data[n_wr[3:0]] <= wr_data;
      n_wr <= n_wr + 1;
    end
    if (frame_error) n_ferr <= n_ferr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi_sck  = 1'b0;
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    spi_ss = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic read_burst(input logic [6:0] a, input int n);
    logic [7:0] rx;
    ss_low();
    xfer_bits({1'b1, a}, 8, rx);
    for (int i = 0; i < n; i++) begin
      xfer_bits(8'h00, 8, rx);
      rx_buf[i] = rx;
    end
    ss_high();
    $display("read  addr=%02h bytes=%0d first=%02h", a, n, rx_buf[0]);
  endtask

  task automatic write_one(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rx;
    ss_low();
    xfer_bits({1'b0, a}, 8, rx);
    xfer_bits(d, 8, rx);
    ss_high();
    $display("write addr=%02h data=%02h", a, d);
  endtask

  task automatic load_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    accel_x_in   = x;
    accel_y_in   = y;
    accel_z_in   = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    $display("sample x=%04h y=%04h z=%04h", x, y, z);
  endtask

  initial begin
    int         wr0, fe0;
    logic [7:0] rx;

    reset = 1'b1;
    spi_ss = 1'b1; spi_sck = 1'b1; spi_mosi = 1'b0;
    accel_x_in = '0; accel_y_in = '0; accel_z_in = '0;
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_pwr",   {24'h0, pwr_mgmt_1},  32'h01);
    check("rst_int",   {24'h0, int_pin_cfg}, 32'h00);
    check("rst_miso",  {31'h0, spi_miso},    32'h0);
    check("rst_oe",    {31'h0, spi_miso_oe}, 32'h0);
    check("rst_wrs",   {31'h0, wr_strobe},   32'h0);
    check("rst_wra",   {25'h0, wr_addr},     32'h0);
    check("rst_wrd",   {24'h0, wr_data},     32'h0);
    check("rst_ferr",  {31'h0, frame_error}, 32'h0);

    // WHO_AM_I
    fe0 = n_ferr;
    read_burst(7'h75, 1);
    check("whoami", {24'h0, rx_buf[0]}, 32'h71);
    check("whoami_ferr", n_ferr - fe0, 0);

    // Accel burst
    load_sample(16'h1234, 16'hABCD, 16'h8001);
    read_burst(7'h3B, 6);
    check("burst0", {24'h0, rx_buf[0]}, 32'h12);
    check("burst1", {24'h0, rx_buf[1]}, 32'h34);
    check("burst2", {24'h0, rx_buf[2]}, 32'hAB);
    check("burst3", {24'h0, rx_buf[3]}, 32'hCD);
    check("burst4", {24'h0, rx_buf[4]}, 32'h80);
    check("burst5", {24'h0, rx_buf[5]}, 32'h01);

    // Register writes
    wr0 = n_wr;
    write_one(7'h6B, 8'h00);
    write_one(7'h37, 8'h02);
    check("wr_pwr",   {24'h0, pwr_mgmt_1},  32'h00);
    check("wr_int",   {24'h0, int_pin_cfg}, 32'h02);
    check("wr_count", n_wr - wr0, 2);
    check("wr_a0", {25'h0, wr_log_addr[wr0[3:0]]},        32'h6B);
    check("wr_d0", {24'h0, wr_log_data[wr0[3:0]]},        32'h00);
    check("wr_a1", {25'h0, wr_log_addr[(wr0 + 1) & 15]},  32'h37);
    check("wr_d1", {24'h0, wr_log_data[(wr0 + 1) & 15]},  32'h02);

    // New sample arriving mid-burst stays pending until SS rises
    ss_low();
    xfer_bits(8'hBB, 8, rx);
    xfer_bits(8'h00, 8, rx);
    rx_buf[0] = rx;
    load_sample(16'h1111, 16'h2222, 16'h3333);
    for (int i = 1; i < 6; i++) begin
      xfer_bits(8'h00, 8, rx);
      rx_buf[i] = rx;
    end
    ss_high();
    $display("read  addr=3b bytes=6 first=%02h (sample mid-burst)", rx_buf[0]);
    check("coh0", {24'h0, rx_buf[0]}, 32'h12);
    check("coh2", {24'h0, rx_buf[2]}, 32'hAB);
    check("coh5", {24'h0, rx_buf[5]}, 32'h01);
    read_burst(7'h3B, 6);
    check("pend_xh", {24'h0, rx_buf[0]}, 32'h11);
    check("pend_xl", {24'h0, rx_buf[1]}, 32'h11);
    check("pend_zh", {24'h0, rx_buf[4]}, 32'h33);

    // Partial write byte is discarded and flagged
    wr0 = n_wr; fe0 = n_ferr;
    ss_low();
    xfer_bits(8'h37, 8, rx);
    xfer_bits(8'hAA, 5, rx);
    ss_high();
    $display("write addr=37 partial 5 bits");
    check("part_ferr", n_ferr - fe0, 1);
    check("part_int",  {24'h0, int_pin_cfg}, 32'h02);
    check("part_wr",   n_wr - wr0, 0);

    // Address-only frame is malformed
    fe0 = n_ferr;
    ss_low();
    xfer_bits(8'hF5, 8, rx);
    ss_high();
    $display("read  addr=75 bytes=0");
    check("noaddr_ferr", n_ferr - fe0, 1);

    // Write burst wraps 0x7F -> 0x00
    wr0 = n_wr;
    ss_low();
    xfer_bits(8'h7F, 8, rx);
    xfer_bits(8'h55, 8, rx);
    xfer_bits(8'h66, 8, rx);
    ss_high();
    $display("write addr=7f data=55 66");
    check("wrap_count", n_wr - wr0, 2);
    check("wrap_a0", {25'h0, wr_log_addr[wr0[3:0]]},       32'h7F);
    check("wrap_a1", {25'h0, wr_log_addr[(wr0 + 1) & 15]}, 32'h00);
    check("wrap_d1", {24'h0, wr_log_data[(wr0 + 1) & 15]}, 32'h66);

    // Reset in the middle of a read frame
    wr0 = n_wr; fe0 = n_ferr;
    ss_low();
    xfer_bits(8'hF5, 8, rx);
    xfer_bits(8'h00, 3, rx);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_pwr", {24'h0, pwr_mgmt_1},  32'h01);
    check("mid_rst_int", {24'h0, int_pin_cfg}, 32'h00);
    check("mid_rst_oe",  {31'h0, spi_miso_oe}, 32'h0);
    check("mid_rst_miso", {31'h0, spi_miso},   32'h0);
    reset = 1'b0;
    xfer_bits(8'h00, 5, rx);
    check("ignored_oe", {31'h0, spi_miso_oe}, 32'h0);
    ss_high();
    $display("read  addr=75 aborted by reset");
    check("ignored_ferr", n_ferr - fe0, 0);
    check("ignored_wr",   n_wr - wr0, 0);
    read_burst(7'h75, 1);
    check("whoami_post", {24'h0, rx_buf[0]}, 32'h71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
